dco_tune_ctrl: RTL and testbench

- Digital loop controller that consumes the ring-oscillator count produced by the frequency-ratio counter.
- Drives the DCO coarse and fine tuning codes so that the measured count converges on a programmed target.
- Acquisition is a coarse binary search, then fine linear tracking with lock detection.
- Sits between the frequency-ratio counter (C_freq source) and the ring oscillator's tuning inputs.

---
 rtl/dco_pkg.sv | 25 ++
 rtl/lock_detect.sv | 54 +++++
 rtl/dco_tune_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dco_tune_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dco_pkg.sv
// Shared types and helpers for the DCO tuning controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dco_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COARSE = 2'b01,
        FINE   = 2'b10,
        LOCK   = 2'b11
    } tune_state_t;

    localparam int DCO_CW = 6;
    localparam int DCO_FW = 8;

    // Magnitude of the 33-bit signed count error. Both operands of the
    // subtraction are zero-extended 32-bit values, so -2^32 never occurs
    // and the negation cannot overflow.
    function automatic logic [32:0] err_abs(input logic signed [32:0] e);
        logic [32:0] r;
        r = e[32] ? 33'(-e) : 33'(e);
        return r;
    endfunction

endpackage

// File: rtl/lock_detect.sv
// Lock qualification: counts consecutive in-tolerance decisions while FINE and
// consecutive out-of-range decisions while LOCK; emits lock_set / lock_clr.
// Latency: outputs are combinational on the decision strobe; counters update on that edge.
// Backpressure: none; strobe is only ever asserted for accepted, non-settling measurements.
// Ports: clk/reset (sync, active-high), abs_err (|err|), strobe (decision), state (FSM state),
//        lock_set (enter LOCK this edge), lock_clr (leave LOCK this edge).
module lock_detect
    import dco_pkg::*;
#(
    parameter int TOL        = 2,
    parameter int UNLOCK_TOL = 8,
    parameter int LOCK_CNT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] abs_err,
    input  logic        strobe,
    input  tune_state_t state,
    output logic        lock_set,
    output logic        lock_clr
);

    localparam int LW = $clog2(LOCK_CNT + 1);

    logic [LW-1:0] lock_cnt;
    logic          unlock_pend;   // one out-of-range sample already seen in LOCK
    logic          in_tol;
    logic          out_rng;

    assign in_tol   = (abs_err <= 33'(TOL));
    assign out_rng  = (abs_err >  33'(UNLOCK_TOL));
    assign lock_set = strobe && (state == FINE) && in_tol && (lock_cnt == LW'(LOCK_CNT - 1));
    assign lock_clr = strobe && (state == LOCK) && out_rng && unlock_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt    <= '0;
            unlock_pend <= 1'b0;
        end else if (strobe) begin
            case (state)
                FINE: lock_cnt <= in_tol ? lock_cnt + LW'(1) : '0;
                LOCK: begin
                    // Second consecutive miss consumes the pending flag and unlocks.
                    unlock_pend <= out_rng && !unlock_pend;
                    if (lock_clr) begin
                        lock_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO loop controller: binary-searches the coarse code, then tracks with the fine code and flags lock.
// Latency: codes/locked/state update on the F_clk edge that samples an accepted meas_valid.
// Backpressure: none; strobes while En=0 or during settling are dropped, never queued.
// Ports: F_clk, Reset (sync, active-high), En, C_freq + meas_valid (measurement), target,
//        coarse_code / fine_code (tuning, larger = faster), locked, state_o (debug).
module dco_tune_ctrl
    import dco_pkg::*;
#(
    parameter int CW          = DCO_CW,
    parameter int FW          = DCO_FW,
    parameter int TOL         = 2,
    parameter int UNLOCK_TOL  = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SETTLE_MEAS = 1
) (
    input  logic          F_clk,
    input  logic          Reset,
    input  logic          En,
    input  logic [31:0]   C_freq,
    input  logic          meas_valid,
    input  logic [31:0]   target,
    output logic [CW-1:0] coarse_code,
    output logic [FW-1:0] fine_code,
    output logic          locked,
    output logic [1:0]    state_o
);

    localparam int PW = (CW > 1) ? $clog2(CW) : 1;
    localparam int SW = (SETTLE_MEAS > 0) ? $clog2(SETTLE_MEAS + 1) : 1;
    localparam logic [CW-1:0] C_MID = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] C_MAX = '1;
    localparam logic [FW-1:0] F_MID = {1'b1, {(FW-1){1'b0}}};
    localparam logic [FW-1:0] F_MAX = '1;
    localparam logic signed [32:0] TOL_P = 33'(TOL);
    localparam logic signed [32:0] TOL_N = -33'(TOL);

    tune_state_t   state, state_nx;
    logic [CW-1:0] coarse_nx;
    logic [FW-1:0] fine_nx;
    logic [PW-1:0] bit_ptr, bit_ptr_nx;
    logic [SW-1:0] settle_cnt, settle_nx;
    logic [31:0]   tgt_r, tgt_nx;
    logic          locked_nx;

    logic signed [32:0] err;
    logic [32:0]        abs_err;
    logic               accept;
    logic               decide;
    logic               lock_set;
    logic               lock_clr;

    // Positive err: ring is running fast, so codes move down.
    assign err     = $signed({1'b0, C_freq}) - $signed({1'b0, tgt_r});
    assign abs_err = err_abs(err);
    assign accept  = En && meas_valid;
    assign decide  = accept && (settle_cnt == '0) && (state != IDLE);
    assign state_o = state;

    lock_detect #(
        .TOL        (TOL),
        .UNLOCK_TOL (UNLOCK_TOL),
        .LOCK_CNT   (LOCK_CNT)
    ) u_lock_detect (
        .clk      (F_clk),
        .reset    (Reset),
        .abs_err  (abs_err),
        .strobe   (decide),
        .state    (state),
        .lock_set (lock_set),
        .lock_clr (lock_clr)
    );

    always_comb begin
        state_nx   = state;
        coarse_nx  = coarse_code;
        fine_nx    = fine_code;
        bit_ptr_nx = bit_ptr;
        settle_nx  = settle_cnt;
        tgt_nx     = tgt_r;
        locked_nx  = locked;

        if (accept && (settle_cnt != '0)) begin
            settle_nx = settle_cnt - SW'(1);
        end

        case (state)
            IDLE: begin
                if (En) begin
                    tgt_nx     = target;
                    bit_ptr_nx = PW'(CW - 1);
                    state_nx   = COARSE;
                    // The MSB trial is already on the outputs; let it settle first.
                    settle_nx  = SW'(SETTLE_MEAS);
                end
            end
            COARSE: begin
                if (decide) begin
                    if (err > 33'sd0) begin
                        coarse_nx[bit_ptr] = 1'b0;
                    end
                    if (bit_ptr != '0) begin
                        coarse_nx[bit_ptr - PW'(1)] = 1'b1;
                        bit_ptr_nx = bit_ptr - PW'(1);
                    end else begin
                        fine_nx  = F_MID;
                        state_nx = FINE;
                    end
                end
            end
            default: begin  // FINE and LOCK share the tracking rule
                if (decide) begin
                    if (err > TOL_P) begin
                        if (fine_code != '0) begin
                            fine_nx = fine_code - FW'(1);
                        end else if (coarse_code != '0) begin
                            coarse_nx = coarse_code - CW'(1);
                            fine_nx   = F_MID;
                        end
                    end else if (err < TOL_N) begin
                        if (fine_code != F_MAX) begin
                            fine_nx = fine_code + FW'(1);
                        end else if (coarse_code != C_MAX) begin
                            coarse_nx = coarse_code + CW'(1);
                            fine_nx   = F_MID;
                        end
                    end
                    if (lock_set) begin
                        state_nx  = LOCK;
                        locked_nx = 1'b1;
                    end
                    if (lock_clr) begin
                        state_nx  = FINE;
                        locked_nx = 1'b0;
                    end
                end
            end
        endcase

        // Any movement of either code invalidates the measurement in flight.
        if ((coarse_nx != coarse_code) || (fine_nx != fine_code)) begin
            settle_nx = SW'(SETTLE_MEAS);
        end
    end

    always_ff @(posedge F_clk) begin
        if (Reset) begin
            state       <= IDLE;
            coarse_code <= C_MID;
            fine_code   <= F_MID;
            bit_ptr     <= '0;
            settle_cnt  <= '0;
            tgt_r       <= '0;
            locked      <= 1'b0;
        end else if (En) begin
            state       <= state_nx;
            coarse_code <= coarse_nx;
            fine_code   <= fine_nx;
            bit_ptr     <= bit_ptr_nx;
            settle_cnt  <= settle_nx;
            tgt_r       <= tgt_nx;
            locked      <= locked_nx;
        end
    end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Bench for dco_tune_ctrl: vector table, hand-written corner sequences, randomized run vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dco_tune_ctrl;

    localparam int TOL    = 2;
    localparam int UNL    = 8;
    localparam int LCNT   = 4;
    localparam int SETTLE = 1;
    localparam logic [31:0] T1 = 32'd51200;

    logic        clk = 1'b0;
    logic        rst, en, mv;
    logic [31:0] cf, tg;
    logic [5:0]  coarse;
    logic [7:0]  fine;
    logic        lk;
    logic [1:0]  st;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (plain integers).
    int          m_st, m_c, m_f, m_w, m_settle, m_run, m_miss;
    bit          m_lk;
    logic [31:0] m_tgt;

    typedef struct {
        bit r;
        bit e;
        bit v;
        int c;
        int ec;
        int ef;
        int el;
        int es;
    } vec_t;
    vec_t tbl[$];

    dco_tune_ctrl dut (
        .F_clk       (clk),
        .Reset       (rst),
        .En          (en),
        .C_freq      (cf),
        .meas_valid  (mv),
        .target      (tg),
        .coarse_code (coarse),
        .fine_code   (fine),
        .locked      (lk),
        .state_o     (st)
    );

    always #5 clk = ~clk;

    // Ring count seen by the controller for a given pair of codes.
    function automatic int dco(int c, int f);
        return 100 * (c * 16 + f / 8);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit e, bit v, logic [31:0] c, logic [31:0] t);
        longint err, aerr;
        int nc, nf;
        if (r) begin
            m_st = 0; m_c = 32; m_f = 128; m_lk = 0; m_tgt = 0;
            m_w = 0; m_settle = 0; m_run = 0; m_miss = 0;
            return;
        end
        if (!e) return;
        if (m_st == 0) begin
            m_tgt = t; m_w = 32; m_settle = SETTLE; m_st = 1;
            return;
        end
        if (!v) return;
        if (m_settle > 0) begin
            m_settle--;
            return;
        end
        err  = longint'({32'd0, c}) - longint'({32'd0, m_tgt});
        aerr = (err < 0) ? -err : err;
        nc = m_c;
        nf = m_f;
        if (m_st == 1) begin
            // Successive approximation by halving weights.
            if (err > 0) nc -= m_w;
            m_w = m_w / 2;
            if (m_w > 0) nc += m_w;
            else begin
                nf = 128;
                m_st = 2;
            end
        end else begin
            if (err > TOL) begin
                if (nf > 0) nf--;
                else if (nc > 0) begin nc--; nf = 128; end
            end else if (err < -TOL) begin
                if (nf < 255) nf++;
                else if (nc < 63) begin nc++; nf = 128; end
            end
            if (m_st == 2) begin
                if (aerr <= TOL) begin
                    m_run++;
                    if (m_run == LCNT) begin m_st = 3; m_lk = 1; end
                end else m_run = 0;
            end else begin
                if (aerr > UNL) begin
                    m_miss++;
                    if (m_miss == 2) begin m_miss = 0; m_run = 0; m_lk = 0; m_st = 2; end
                end else m_miss = 0;
            end
        end
        if (nc != m_c || nf != m_f) m_settle = SETTLE;
        m_c = nc;
        m_f = nf;
    endtask

    // One clock: drive, advance model on the edge, compare on the falling edge.
    task automatic tick(bit r, bit e, bit v, logic [31:0] c, logic [31:0] t);
        rst = r; en = e; mv = v; cf = c; tg = t;
        @(posedge clk);
        model_step(r, e, v, c, t);
        @(negedge clk);
        chk("model_coarse", 32'(coarse), 32'(m_c));
        chk("model_fine",   32'(fine),   32'(m_f));
        chk("model_locked", 32'(lk),     32'(m_lk));
        chk("model_state",  32'(st),     32'(m_st));
    endtask

    task automatic add(bit r, bit e, bit v, int c, int ec, int ef, int el, int es);
        vec_t x;
        x.r = r; x.e = e; x.v = v; x.c = c;
        x.ec = ec; x.ef = ef; x.el = el; x.es = es;
        tbl.push_back(x);
    endtask

    task automatic chk_codes(string name, int ec, int ef, int el, int es);
        chk({name, "_coarse"}, 32'(coarse), 32'(ec));
        chk({name, "_fine"},   32'(fine),   32'(ef));
        chk({name, "_locked"}, 32'(lk),     32'(el));
        chk({name, "_state"},  32'(st),     32'(es));
    endtask

    initial begin
        // Reset (priority over En), hold with En=0, binary search, lock, unlock hysteresis.
        add(1,1,1,0,     32,128,0,0);
        add(1,0,0,0,     32,128,0,0);
        add(0,0,1,0,     32,128,0,0);
        add(0,0,1,52800, 32,128,0,0);
        add(0,1,0,0,     32,128,0,1);
        add(0,1,1,52800, 32,128,0,1);
        add(0,1,1,52800, 16,128,0,1);
        add(0,1,1,27200, 16,128,0,1);
        add(0,1,1,27200, 24,128,0,1);
        add(0,0,1,0,     24,128,0,1);
        add(0,1,0,0,     24,128,0,1);
        add(0,1,1,40000, 24,128,0,1);
        add(0,1,1,40000, 28,128,0,1);
        add(0,1,1,46400, 28,128,0,1);
        add(0,1,1,46400, 30,128,0,1);
        add(0,1,1,49600, 30,128,0,1);
        add(0,1,1,49600, 31,128,0,1);
        add(0,1,1,51200, 31,128,0,1);
        add(0,1,1,51200, 31,128,0,2);
        add(0,1,1,51200, 31,128,0,2);
        add(0,1,1,51201, 31,128,0,2);
        add(0,1,1,51198, 31,128,0,2);
        add(0,1,1,51200, 31,128,1,3);
        add(0,1,1,51220, 31,127,1,3);
        add(0,1,1,51220, 31,127,1,3);
        add(0,1,1,51201, 31,127,1,3);
        add(0,1,1,51220, 31,126,1,3);
        add(0,1,1,51220, 31,126,1,3);
        add(0,1,1,51220, 31,125,0,2);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].r, tbl[i].e, tbl[i].v, 32'(tbl[i].c), T1);
            chk_codes($sformatf("vec%0d", i), tbl[i].ec, tbl[i].ef, tbl[i].el, tbl[i].es);
        end

        // Fine underflow borrows from coarse: err=+50 walks fine 125 -> 0, then coarse-1 / midscale.
        for (int i = 1; i <= 252; i++) begin
            tick(0, 1, 1, T1 + 32'd50, T1);
            if (i == 250) chk_codes("fine_floor", 31, 0, 0, 2);
            if (i == 252) chk_codes("fine_borrow", 30, 128, 0, 2);
        end

        // Both codes at zero with err=+50: everything holds.
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        for (int i = 1; i <= 275; i++) tick(0, 1, 1, 32'd50, 32'd0);
        chk_codes("both_floor", 0, 0, 0, 2);

        // Reset after three coarse decisions, then re-acquire a new target.
        tick(1, 0, 0, 0, T1);
        tick(1, 0, 0, 0, T1);
        tick(0, 1, 0, 0, T1);
        for (int i = 0; i < 6; i++) tick(0, 1, 1, 32'(dco(m_c, m_f)), T1);
        chk_codes("mid_coarse", 28, 128, 0, 1);
        tick(1, 1, 1, 32'd0, T1);
        chk_codes("mid_reset", 32, 128, 0, 0);
        tick(0, 1, 0, 0, 32'd25600);
        for (int i = 0; i < 12; i++) tick(0, 1, 1, 32'(dco(m_c, m_f)), 32'd999);
        chk_codes("reacquire", 15, 128, 0, 2);

        // Randomized operation against the model.
        for (int round = 0; round < 4; round++) begin
            logic [31:0] rt;
            rt = 32'(100 * $urandom_range(20, 1000));
            tick(1, 0, 0, 0, rt);
            tick(1, 0, 0, 0, rt);
            for (int i = 0; i < 2500; i++) begin
                int n, cv;
                bit e, v, r;
                e = ($urandom_range(0, 15) != 0);
                v = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 1499) == 0);
                if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) != 0) ? 20 : -20;
                else n = int'($urandom_range(0, 4)) - 2;
                cv = dco(m_c, m_f) + n;
                if (cv < 0) cv = 0;
                if ($urandom_range(0, 299) == 0) rt = 32'(100 * $urandom_range(20, 1000));
                tick(r, e, v, 32'(cv), rt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
